alu_arbiter: RTL and testbench

//  Shares one registered ALU (1-cycle sample-to-result) between N_REQ requesters.

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter_rr_pick.sv | 35 +++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU operation/carry encodings and the arbiter FSM states.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ADD      = 2'd0,
    SUBTRACT = 2'd1,
    MULTIPLY = 2'd2
  } sel_t;

  typedef enum logic {
    NO_CARRY   = 1'b0,
    WITH_CARRY = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requester clients (master) and the ALU arbiter (slave).
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OP_W  = 4,
  parameter int RES_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        Req_Valid;
  logic [N_REQ-1:0]        Req_Ready;
  logic [N_REQ*OP_W-1:0]   Req_Op1;
  logic [N_REQ*OP_W-1:0]   Req_Op2;
  sel_t  [N_REQ-1:0]       Req_Sel;
  mode_t [N_REQ-1:0]       Req_Mode;
  logic [N_REQ-1:0]        Req_C_In;
  logic                    Rsp_Valid;
  logic                    Rsp_Ready;
  logic [ID_W-1:0]         Rsp_Id;
  logic [RES_W-1:0]        Rsp_Result;
  logic                    Rsp_Equal;

  modport master (
    output Req_Valid, Req_Op1, Req_Op2, Req_Sel, Req_Mode, Req_C_In, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Equal
  );

  modport slave (
    input  Req_Valid, Req_Op1, Req_Op2, Req_Sel, Req_Mode, Req_C_In, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Equal
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping modulo N_REQ.
module alu_arbiter_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  localparam int SUM_W = ID_W + 1;

  logic [ID_W-1:0] cand [N_REQ];

  // cand[k] is the requester k positions after ptr; ptr is always < N_REQ so one subtract wraps.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [SUM_W-1:0] sum;
    assign sum = {1'b0, ptr} + SUM_W'(gi);
    assign cand[gi] = (sum >= SUM_W'(N_REQ)) ? ID_W'(sum - SUM_W'(N_REQ)) : sum[ID_W-1:0];
  end

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid[cand[k]]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
    grant = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between N_REQ requesters, one op in flight.
// Define ALU_ARB_CNT_EN to add the saturating Op_Count output of completed responses.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OP_W  = 4,
  parameter int RES_W = 8
) (
  input  logic             Clock,
  input  logic             Reset_N,
  alu_arbiter_if.slave     bus,
  output logic [OP_W-1:0]  Alu_Op1,
  output logic [OP_W-1:0]  Alu_Op2,
  output sel_t             Alu_Sel,
  output mode_t            Alu_Mode,
  output logic             Alu_C_In,
  input  logic [RES_W-1:0] Alu_Result,
  input  logic             Alu_Equal
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] Op_Count
`endif
);
  localparam int ID_W = $clog2(N_REQ);

  arb_state_t       state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  id_reg;
  logic [OP_W-1:0]  op1_reg;
  logic [OP_W-1:0]  op2_reg;
  sel_t             sel_reg;
  mode_t            mode_reg;
  logic             c_in_reg;
  logic             rsp_valid_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic [RES_W-1:0] rsp_result_reg;
  logic             rsp_equal_reg;

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [ID_W-1:0]  ptr_next;
  logic             rsp_fire;

  alu_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .ptr   (ptr_reg),
    .valid (bus.Req_Valid),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign ptr_next = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
  assign rsp_fire = rsp_valid_reg & bus.Rsp_Ready;

  // Grant is offered only while idle and out of reset, so at most one requester sees ready.
  assign bus.Req_Ready  = (Reset_N && state_reg == IDLE) ? pick_grant : '0;
  assign bus.Rsp_Valid  = rsp_valid_reg;
  assign bus.Rsp_Id     = rsp_id_reg;
  assign bus.Rsp_Result = rsp_result_reg;
  assign bus.Rsp_Equal  = rsp_equal_reg;

  assign Alu_Op1  = op1_reg;
  assign Alu_Op2  = op2_reg;
  assign Alu_Sel  = sel_reg;
  assign Alu_Mode = mode_reg;
  assign Alu_C_In = c_in_reg;

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      id_reg         <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      sel_reg        <= ADD;
      mode_reg       <= NO_CARRY;
      c_in_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_equal_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            op1_reg   <= bus.Req_Op1[pick_idx*OP_W +: OP_W];
            op2_reg   <= bus.Req_Op2[pick_idx*OP_W +: OP_W];
            sel_reg   <= bus.Req_Sel[pick_idx];
            mode_reg  <= bus.Req_Mode[pick_idx];
            c_in_reg  <= bus.Req_C_In[pick_idx];
            id_reg    <= pick_idx;
            ptr_reg   <= ptr_next;
            state_reg <= ISSUE;
          end
        end
        ISSUE: state_reg <= WAIT;
        WAIT: begin
          // ALU sampled the op regs at the end of ISSUE, so its outputs are settled here.
          rsp_result_reg <= Alu_Result;
          rsp_equal_reg  <= Alu_Equal;
          rsp_id_reg     <= id_reg;
          rsp_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_CNT_EN
  logic [CNT_W-1:0] op_count_reg;

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      op_count_reg <= '0;
    end else if (rsp_fire && op_count_reg != CNT_MAX) begin
      op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end

  assign Op_Count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered stand-in ALU; define ALU_ARB_CNT_EN to cover Op_Count.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N_REQ = 4;
  localparam int OP_W  = 4;
  localparam int RES_W = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_arbiter_if #(.N_REQ(N_REQ), .OP_W(OP_W), .RES_W(RES_W)) bus ();

  logic [OP_W-1:0]  alu_op1;
  logic [OP_W-1:0]  alu_op2;
  sel_t             alu_sel;
  mode_t            alu_mode;
  logic             alu_c_in;
  logic [RES_W-1:0] alu_result;
  logic             alu_equal;
`ifdef ALU_ARB_CNT_EN
  logic [15:0]      op_count;
`endif

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.N_REQ(N_REQ), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .Clock      (clock),
    .Reset_N    (reset_n),
    .bus        (bus),
    .Alu_Op1    (alu_op1),
    .Alu_Op2    (alu_op2),
    .Alu_Sel    (alu_sel),
    .Alu_Mode   (alu_mode),
    .Alu_C_In   (alu_c_in),
    .Alu_Result (alu_result),
    .Alu_Equal  (alu_equal)
`ifdef ALU_ARB_CNT_EN
    ,
    .Op_Count   (op_count)
`endif
  );

  // Stand-in for the shared ALU: samples its inputs on every posedge.
  logic [RES_W-1:0] a_ext, b_ext, c_ext;
  assign a_ext = RES_W'(alu_op1);
  assign b_ext = RES_W'(alu_op2);
  assign c_ext = RES_W'(alu_mode == WITH_CARRY && alu_c_in);

  always_ff @(posedge clock) begin
    alu_equal <= (alu_op1 == alu_op2);
    case (alu_sel)
      ADD:      alu_result <= a_ext + b_ext + c_ext;
      SUBTRACT: alu_result <= a_ext - b_ext - c_ext;
      MULTIPLY: alu_result <= a_ext * b_ext;
      default:  alu_result <= '0;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_req(input int idx, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input sel_t sel, input mode_t mode, input logic cin);
    bus.Req_Op1[idx*OP_W +: OP_W] = a;
    bus.Req_Op2[idx*OP_W +: OP_W] = b;
    bus.Req_Sel[idx]   = sel;
    bus.Req_Mode[idx]  = mode;
    bus.Req_C_In[idx]  = cin;
    bus.Req_Valid[idx] = 1'b1;
    #1;
  endtask

  // Waits (bounded) for a grant, returns it, and steps past the accepting edge.
  task automatic wait_accept(output bit ok, output logic [N_REQ-1:0] gnt);
    int n = 0;
    while (bus.Req_Ready == '0 && n < 20) begin
      tick();
      n++;
    end
    ok  = (bus.Req_Ready != '0);
    gnt = bus.Req_Ready;
    tick();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.Req_Valid = '1;
    bus.Rsp_Ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.Req_Ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_req_ready actual=%b expected=0000", bus.Req_Ready);
    end
    checks++;
    if (bus.Rsp_Valid !== 1'b0 || bus.Rsp_Id !== 2'd0 || bus.Rsp_Result !== 8'd0 || bus.Rsp_Equal !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp actual=v%b id%0d r%0d eq%b expected=v0 id0 r0 eq0",
               bus.Rsp_Valid, bus.Rsp_Id, bus.Rsp_Result, bus.Rsp_Equal);
    end
    checks++;
    if (alu_sel !== ADD || alu_mode !== NO_CARRY || alu_op1 !== 4'd0 || alu_op2 !== 4'd0 || alu_c_in !== 1'b0) begin
      failures++;
      $display("FAIL reset_alu_drive actual=sel%0d mode%0d op1=%0d op2=%0d cin=%b expected=sel0 mode0 op1=0 op2=0 cin=0",
               alu_sel, alu_mode, alu_op1, alu_op2, alu_c_in);
    end
    bus.Req_Valid = '0;
    bus.Rsp_Ready = 1'b0;
    reset_n = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_single_op();
    load_req(0, 4'd3, 4'd4, ADD, NO_CARRY, 1'b0);
    checks++;
    if (bus.Req_Ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant actual=%b expected=0001", bus.Req_Ready);
    end
    tick();  // E0
    bus.Req_Valid[0] = 1'b0;
    #1;
    checks++;
    if (bus.Req_Ready !== 4'b0000 || bus.Rsp_Valid !== 1'b0 || alu_op1 !== 4'd3 || alu_op2 !== 4'd4 || alu_sel !== ADD) begin
      failures++;
      $display("FAIL single_issue actual=rdy%b v%b op1=%0d op2=%0d sel%0d expected=rdy0000 v0 op1=3 op2=4 sel0",
               bus.Req_Ready, bus.Rsp_Valid, alu_op1, alu_op2, alu_sel);
    end
    tick();  // E1
    checks++;
    if (bus.Rsp_Valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid actual=%b expected=0", bus.Rsp_Valid);
    end
    tick();  // E2
    checks++;
    if (bus.Rsp_Valid !== 1'b1 || bus.Rsp_Result !== 8'd7 || bus.Rsp_Equal !== 1'b0 || bus.Rsp_Id !== 2'd0) begin
      failures++;
      $display("FAIL single_rsp actual=v%b r%0d eq%b id%0d expected=v1 r7 eq0 id0",
               bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Equal, bus.Rsp_Id);
    end
    $display("op id=%0d result=%0d equal=%b", bus.Rsp_Id, bus.Rsp_Result, bus.Rsp_Equal);
    bus.Rsp_Ready = 1'b1;
    tick();
    bus.Rsp_Ready = 1'b0;
    checks++;
    if (bus.Rsp_Valid !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp_clear actual=%b expected=0", bus.Rsp_Valid);
    end
  endtask

  task automatic test_carry_mode();
    int           idx_tab [5] = '{2, 1, 3, 0, 1};
    logic [3:0]   a_tab   [5] = '{4'd9, 4'd15, 4'd5, 4'd7, 4'd6};
    logic [3:0]   b_tab   [5] = '{4'd4, 4'd15, 4'd5, 4'd8, 4'd2};
    sel_t         sel_tab [5] = '{SUBTRACT, MULTIPLY, ADD, ADD, sel_t'(2'd3)};
    mode_t        mode_tab[5] = '{WITH_CARRY, NO_CARRY, NO_CARRY, WITH_CARRY, NO_CARRY};
    logic         cin_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]   res_tab [5] = '{8'd4, 8'd225, 8'd10, 8'd16, 8'd0};
    logic         eq_tab  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit ok;
    logic [N_REQ-1:0] gnt;
    for (int k = 0; k < 5; k++) begin
      load_req(idx_tab[k], a_tab[k], b_tab[k], sel_tab[k], mode_tab[k], cin_tab[k]);
      wait_accept(ok, gnt);
      bus.Req_Valid = '0;
      checks++;
      if (!ok || gnt !== N_REQ'(1) << idx_tab[k]) begin
        failures++;
        $display("FAIL carry_grant_%0d actual=%b expected_one_hot_bit=%0d", k, gnt, idx_tab[k]);
      end
      checks++;
      if (alu_sel !== sel_tab[k] || alu_mode !== mode_tab[k] || alu_c_in !== cin_tab[k]) begin
        failures++;
        $display("FAIL carry_fwd_%0d actual=sel%0d mode%0d cin%b expected=sel%0d mode%0d cin%b",
                 k, alu_sel, alu_mode, alu_c_in, sel_tab[k], mode_tab[k], cin_tab[k]);
      end
      tick();
      tick();
      checks++;
      if (bus.Rsp_Valid !== 1'b1 || bus.Rsp_Result !== res_tab[k] || bus.Rsp_Equal !== eq_tab[k] ||
          bus.Rsp_Id !== 2'(idx_tab[k])) begin
        failures++;
        $display("FAIL carry_rsp_%0d actual=v%b r%0d eq%b id%0d expected=v1 r%0d eq%b id%0d",
                 k, bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Equal, bus.Rsp_Id, res_tab[k], eq_tab[k], idx_tab[k]);
      end
      $display("op id=%0d result=%0d equal=%b", bus.Rsp_Id, bus.Rsp_Result, bus.Rsp_Equal);
      bus.Rsp_Ready = 1'b1;
      tick();
      bus.Rsp_Ready = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int exp_id  [5] = '{0, 1, 2, 3, 0};
    int seen = 0;
    int cyc  = 0;
    int last = 0;
    pulse_reset();
    for (int i = 0; i < N_REQ; i++) load_req(i, 4'(i), 4'd1, ADD, NO_CARRY, 1'b0);
    bus.Rsp_Ready = 1'b1;
    while (seen < 5 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.Rsp_Valid === 1'b1) begin
        checks++;
        if (bus.Rsp_Id !== 2'(exp_id[seen]) || bus.Rsp_Result !== 8'(exp_id[seen] + 1)) begin
          failures++;
          $display("FAIL fair_order_%0d actual=id%0d r%0d expected=id%0d r%0d",
                   seen, bus.Rsp_Id, bus.Rsp_Result, exp_id[seen], exp_id[seen] + 1);
        end
        if (seen > 0) begin
          checks++;
          if (cyc - last != 4) begin
            failures++;
            $display("FAIL fair_spacing_%0d actual=%0d expected=4", seen, cyc - last);
          end
        end
        $display("op id=%0d result=%0d cycle=%0d", bus.Rsp_Id, bus.Rsp_Result, cyc);
        last = cyc;
        seen++;
      end
    end
    checks++;
    if (seen != 5) begin
      failures++;
      $display("FAIL fair_count actual=%0d expected=5", seen);
    end
    bus.Req_Valid = '0;
    tick();
    bus.Rsp_Ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [N_REQ-1:0] gnt;
    load_req(3, 4'd2, 4'd9, ADD, NO_CARRY, 1'b0);
    wait_accept(ok, gnt);
    bus.Req_Valid = '0;
    checks++;
    if (!ok || gnt !== 4'b1000) begin
      failures++;
      $display("FAIL bp_grant actual=%b expected=1000", gnt);
    end
    tick();
    tick();
    bus.Req_Valid = 4'b0111;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.Rsp_Valid !== 1'b1 || bus.Rsp_Result !== 8'd11 || bus.Rsp_Id !== 2'd3 ||
          bus.Rsp_Equal !== 1'b0 || bus.Req_Ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold_%0d actual=v%b r%0d id%0d eq%b rdy%b expected=v1 r11 id3 eq0 rdy0000",
                 c, bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Id, bus.Rsp_Equal, bus.Req_Ready);
      end
      tick();
    end
    $display("op id=%0d result=%0d held", bus.Rsp_Id, bus.Rsp_Result);
    bus.Req_Valid = '0;
    bus.Rsp_Ready = 1'b1;
    tick();
    bus.Rsp_Ready = 1'b0;
    checks++;
    if (bus.Rsp_Valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release actual=%b expected=0", bus.Rsp_Valid);
    end
    load_req(1, 4'd1, 4'd1, ADD, NO_CARRY, 1'b0);
    checks++;
    if (bus.Req_Ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_idle_grant actual=%b expected=0010", bus.Req_Ready);
    end
    // Withdrawn before any edge: must never produce a response.
    bus.Req_Valid = '0;
    #1;
    begin
      bit any_rsp = 1'b0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (bus.Rsp_Valid !== 1'b0) any_rsp = 1'b1;
      end
      checks++;
      if (any_rsp) begin
        failures++;
        $display("FAIL bp_withdrawn actual=response expected=none");
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    logic [N_REQ-1:0] gnt;
    bit any_rsp = 1'b0;
    load_req(2, 4'd3, 4'd5, MULTIPLY, NO_CARRY, 1'b0);
    wait_accept(ok, gnt);
    bus.Req_Valid = '0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_accept actual=timeout expected=grant");
    end
    tick();  // now in WAIT
    reset_n = 1'b0;
    tick();
    checks++;
    if (bus.Rsp_Valid !== 1'b0 || alu_op1 !== 4'd0 || alu_sel !== ADD || bus.Rsp_Result !== 8'd0) begin
      failures++;
      $display("FAIL midrst_state actual=v%b op1=%0d sel%0d r%0d expected=v0 op1=0 sel0 r0",
               bus.Rsp_Valid, alu_op1, alu_sel, bus.Rsp_Result);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.Rsp_Valid !== 1'b0) any_rsp = 1'b1;
    end
    checks++;
    if (any_rsp) begin
      failures++;
      $display("FAIL midrst_no_rsp actual=response expected=none");
    end
    bus.Req_Valid = '1;
    #1;
    checks++;
    if (bus.Req_Ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_ptr actual=%b expected=0001", bus.Req_Ready);
    end
    bus.Req_Valid = '0;
    #1;
    $display("reset mid-op done");
  endtask

`ifdef ALU_ARB_CNT_EN
  task automatic run_one_op();
    bit ok;
    logic [N_REQ-1:0] gnt;
    load_req(0, 4'd1, 4'd2, ADD, NO_CARRY, 1'b0);
    wait_accept(ok, gnt);
    bus.Req_Valid = '0;
    bus.Rsp_Ready = 1'b1;
    tick();
    tick();
    tick();
    bus.Rsp_Ready = 1'b0;
  endtask

  task automatic test_op_count();
    pulse_reset();
    checks++;
    if (op_count !== 16'd0) begin
      failures++;
      $display("FAIL cnt_reset actual=%0d expected=0", op_count);
    end
    for (int i = 0; i < 3; i++) run_one_op();
    checks++;
    if (op_count !== 16'd3) begin
      failures++;
      $display("FAIL cnt_three actual=%0d expected=3", op_count);
    end
    pulse_reset();
    checks++;
    if (op_count !== 16'd0) begin
      failures++;
      $display("FAIL cnt_rereset actual=%0d expected=0", op_count);
    end
    force dut.op_count_reg = 16'hFFFF;
    tick();
    release dut.op_count_reg;
    run_one_op();
    checks++;
    if (op_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_saturate actual=%h expected=ffff", op_count);
    end
    $display("op count=%h", op_count);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Req_Valid = '0;
    bus.Req_Op1   = '0;
    bus.Req_Op2   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.Req_Sel[i]  = ADD;
      bus.Req_Mode[i] = NO_CARRY;
    end
    bus.Req_C_In  = '0;
    bus.Rsp_Ready = 1'b0;
    test_reset();
    test_single_op();
    test_carry_mode();
    test_fairness();
    test_backpressure();
    test_reset_mid_op();
`ifdef ALU_ARB_CNT_EN
    test_op_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
